// File: rtl/aead_job_sequencer.sv
// Runs one authenticated-encryption job at a time: latch operands, pulse core reset,
// wait for core_done under a timeout, then hold the result until the host takes it.
`timescale 1ns/1ps
module aead_job_sequencer #(
    parameter int unsigned W           = 128,
    parameter int unsigned RST_CYCLES  = 4,
    parameter int unsigned MAX_WAIT    = 4096,
    parameter int unsigned CORE_RST_HI = 1
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         job_valid,
    output logic         job_ready,
    input  logic [W-1:0] job_key,
    input  logic [W-1:0] job_seed,
    input  logic [W-1:0] job_ad,
    input  logic [W-1:0] job_nonce,
    input  logic [W-1:0] job_pt,
    output logic         core_rst,
    output logic [W-1:0] core_k,
    output logic [W-1:0] core_s,
    output logic [W-1:0] core_a,
    output logic [W-1:0] core_n,
    output logic [W-1:0] core_p,
    input  logic [W-1:0] core_c,
    input  logic         core_tag,
    input  logic         core_done,
    output logic         res_valid,
    input  logic         res_ready,
    output logic [W-1:0] res_ct,
    output logic         res_tag,
    output logic         res_timeout,
    output logic         busy
);

    localparam int unsigned CNT_MAX = (RST_CYCLES > MAX_WAIT) ? RST_CYCLES : MAX_WAIT;
    localparam int unsigned CW      = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;
    localparam logic        RST_ON  = (CORE_RST_HI != 0);
    localparam logic [CW-1:0] RST_LAST  = CW'(RST_CYCLES - 1);
    localparam logic [CW-1:0] WAIT_LAST = CW'(MAX_WAIT - 1);

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        CORE_RST = 2'd1,
        RUN      = 2'd2,
        RESULT   = 2'd3
    } state_t;

    state_t        state, state_d;
    logic [CW-1:0] cnt, cnt_d;

    logic load_ops;
    logic cap_done;
    logic cap_to;
    logic ready_d;
    logic valid_d;
    logic rst_on_d;

    // State register plus every registered output
    always_ff @(posedge clk) begin
        if (!rst) begin
            state       <= IDLE;
            cnt         <= '0;
            job_ready   <= 1'b1;
            busy        <= 1'b0;
            res_valid   <= 1'b0;
            core_rst    <= RST_ON;
            core_k      <= '0;
            core_s      <= '0;
            core_a      <= '0;
            core_n      <= '0;
            core_p      <= '0;
            res_ct      <= '0;
            res_tag     <= 1'b0;
            res_timeout <= 1'b0;
        end else begin
            state     <= state_d;
            cnt       <= cnt_d;
            job_ready <= ready_d;
            busy      <= ~ready_d;
            res_valid <= valid_d;
            core_rst  <= rst_on_d ? RST_ON : ~RST_ON;
            if (load_ops) begin
                core_k <= job_key;
                core_s <= job_seed;
                core_a <= job_ad;
                core_n <= job_nonce;
                core_p <= job_pt;
            end
            if (cap_done) begin
                res_ct      <= core_c;
                res_tag     <= core_tag;
                res_timeout <= 1'b0;
            end else if (cap_to) begin
                res_ct      <= '0;
                res_tag     <= 1'b0;
                res_timeout <= 1'b1;
            end
        end
    end

    // Next-state and cycle counter
    always_comb begin
        state_d = state;
        cnt_d   = cnt;
        unique case (state)
            IDLE: begin
                if (job_valid) begin
                    state_d = CORE_RST;
                    cnt_d   = '0;
                end
            end
            CORE_RST: begin
                if (cnt == RST_LAST) begin
                    state_d = RUN;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt + CW'(1);
                end
            end
            RUN: begin
                if (core_done || cnt == WAIT_LAST) begin
                    state_d = RESULT;
                end else begin
                    cnt_d = cnt + CW'(1);
                end
            end
            RESULT: begin
                if (res_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Load/capture strobes and next values of the registered flags; done beats timeout
    always_comb begin
        load_ops = (state == IDLE) && job_valid;
        cap_done = (state == RUN) && core_done;
        cap_to   = (state == RUN) && !core_done && (cnt == WAIT_LAST);
        ready_d  = (state_d == IDLE);
        valid_d  = (state_d == RESULT);
        rst_on_d = (state_d != RUN);
    end

endmodule

// File: tb/tb_aead_job_sequencer.sv
// Directed bench: instance a uses MAX_WAIT=4096, instance b uses MAX_WAIT=16 for timeout cases.
`timescale 1ns/1ps
module tb_aead_job_sequencer;

    localparam int unsigned W  = 128;
    localparam int unsigned RC = 4;

    logic         clk = 1'b0;
    logic         rst = 1'b0;
    logic [W-1:0] key = '0, seed = '0, ad = '0, nonce = '0, pt = '0;
    logic [W-1:0] cc = '0;
    logic         ctag = 1'b0;

    logic         jv_a = 1'b0, jv_b = 1'b0;
    logic         rr_a = 1'b0, rr_b = 1'b0;
    logic         jr_a, jr_b, crst_a, crst_b, done_a, done_b;
    logic         rv_a, rv_b, rtag_a, rtag_b, rto_a, rto_b, busy_a, busy_b;
    logic [W-1:0] ck_a, cs_a, ca_a, cn_a, cp_a, rct_a;
    logic [W-1:0] ck_b, cs_b, ca_b, cn_b, cp_b, rct_b;

    int n_chk  = 0;
    int n_fail = 0;
    int dly_a  = 0, dly_b = 0;
    int rc_a   = 0, rc_b  = 0;
    int lat;

    always #5 clk = ~clk;

    // Core model: done high during the dly-th cycle after core reset release (dly=0: never)
    always @(posedge clk) rc_a <= crst_a ? 0 : rc_a + 1;
    always @(posedge clk) rc_b <= crst_b ? 0 : rc_b + 1;
    assign done_a = !crst_a && (dly_a != 0) && (rc_a == dly_a - 1);
    assign done_b = !crst_b && (dly_b != 0) && (rc_b == dly_b - 1);

    aead_job_sequencer #(.W(W), .RST_CYCLES(RC), .MAX_WAIT(4096), .CORE_RST_HI(1)) dut_a (
        .clk(clk), .rst(rst), .job_valid(jv_a), .job_ready(jr_a),
        .job_key(key), .job_seed(seed), .job_ad(ad), .job_nonce(nonce), .job_pt(pt),
        .core_rst(crst_a), .core_k(ck_a), .core_s(cs_a), .core_a(ca_a), .core_n(cn_a), .core_p(cp_a),
        .core_c(cc), .core_tag(ctag), .core_done(done_a),
        .res_valid(rv_a), .res_ready(rr_a), .res_ct(rct_a), .res_tag(rtag_a),
        .res_timeout(rto_a), .busy(busy_a)
    );

    aead_job_sequencer #(.W(W), .RST_CYCLES(RC), .MAX_WAIT(16), .CORE_RST_HI(1)) dut_b (
        .clk(clk), .rst(rst), .job_valid(jv_b), .job_ready(jr_b),
        .job_key(key), .job_seed(seed), .job_ad(ad), .job_nonce(nonce), .job_pt(pt),
        .core_rst(crst_b), .core_k(ck_b), .core_s(cs_b), .core_a(ca_b), .core_n(cn_b), .core_p(cp_b),
        .core_c(cc), .core_tag(ctag), .core_done(done_b),
        .res_valid(rv_b), .res_ready(rr_b), .res_ct(rct_b), .res_tag(rtag_b),
        .res_timeout(rto_b), .busy(busy_b)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chkw(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic chkb(input string tag, input logic obs, input logic exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    task automatic chki(input string tag, input int obs, input int exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Count cycles from accept (first cycle after accept edge = 1) until res_valid, bounded
    task automatic wait_valid(input bit use_b, output int l);
        l = 1;
        while (!(use_b ? rv_b : rv_a) && l < 200) begin
            step();
            l++;
        end
    endtask

    initial begin
        // Reset state
        repeat (3) step();
        chkb("rst_job_ready", jr_a, 1'b1);
        chkb("rst_res_valid", rv_a, 1'b0);
        chkb("rst_busy", busy_a, 1'b0);
        chkb("rst_core_rst", crst_a, 1'b1);
        chkw("rst_core_k", ck_a, '0);
        chkw("rst_res_ct", rct_a, '0);
        chkb("rst_res_timeout", rto_a, 1'b0);
        rst = 1'b1;
        step();

        // Normal job, done on 20th RUN cycle
        key = 128'h1; seed = 128'h5EED; ad = 128'hAD; nonce = 128'h11; pt = 128'hAB;
        cc = 128'hDEAD; ctag = 1'b1; dly_a = 20;
        jv_a = 1'b1;
        step();
        jv_a = 1'b0;
        chkw("acc_core_k", ck_a, 128'h1);
        chkw("acc_core_s", cs_a, 128'h5EED);
        chkw("acc_core_a", ca_a, 128'hAD);
        chkw("acc_core_n", cn_a, 128'h11);
        chkw("acc_core_p", cp_a, 128'hAB);
        chkb("acc_busy", busy_a, 1'b1);
        chkb("acc_job_ready", jr_a, 1'b0);
        chkb("acc_core_rst", crst_a, 1'b1);
        key = 128'hFFFF;
        wait_valid(1'b0, lat);
        chki("norm_latency", lat, RC + 21);
        chkw("norm_res_ct", rct_a, 128'hDEAD);
        chkb("norm_res_tag", rtag_a, 1'b1);
        chkb("norm_res_timeout", rto_a, 1'b0);
        chkb("norm_core_rst", crst_a, 1'b1);
        chkw("iso_core_k", ck_a, 128'h1);

        // Backpressure with a pending job_valid and changing core output
        key = 128'h2222; cc = 128'hBEEF; ctag = 1'b0; dly_a = 1;
        jv_a = 1'b1;
        for (int i = 0; i < 50; i++) begin
            step();
            chkb("bp_res_valid", rv_a, 1'b1);
            chkw("bp_res_ct", rct_a, 128'hDEAD);
            chkb("bp_res_tag", rtag_a, 1'b1);
            chkb("bp_job_ready", jr_a, 1'b0);
            chkw("bp_core_k", ck_a, 128'h1);
        end
        rr_a = 1'b1;
        step();
        rr_a = 1'b0;
        chkb("rel_res_valid", rv_a, 1'b0);
        chkb("rel_job_ready", jr_a, 1'b1);
        chkb("rel_busy", busy_a, 1'b0);
        chkw("rel_core_k", ck_a, 128'h1);
        step();
        jv_a = 1'b0;
        chkw("next_core_k", ck_a, 128'h2222);
        chkb("next_busy", busy_a, 1'b1);

        // Done on first RUN cycle
        wait_valid(1'b0, lat);
        chki("first_run_latency", lat, RC + 2);
        chkw("first_run_res_ct", rct_a, 128'hBEEF);
        chkb("first_run_res_tag", rtag_a, 1'b0);
        chkb("first_run_timeout", rto_a, 1'b0);
        rr_a = 1'b1;
        step();
        rr_a = 1'b0;

        // Timeout on instance b (MAX_WAIT=16)
        cc = 128'hDEAD; ctag = 1'b1; key = 128'h33; dly_b = 0;
        jv_b = 1'b1;
        step();
        jv_b = 1'b0;
        chkw("b_core_k", ck_b, 128'h33);
        wait_valid(1'b1, lat);
        chki("to_latency", lat, RC + 17);
        chkb("to_res_timeout", rto_b, 1'b1);
        chkw("to_res_ct", rct_b, '0);
        chkb("to_res_tag", rtag_b, 1'b0);
        rr_b = 1'b1;
        step();
        rr_b = 1'b0;

        // Done coincides with the last allowed RUN cycle
        dly_b = 16;
        jv_b = 1'b1;
        step();
        jv_b = 1'b0;
        wait_valid(1'b1, lat);
        chki("edge_latency", lat, RC + 17);
        chkb("edge_res_timeout", rto_b, 1'b0);
        chkw("edge_res_ct", rct_b, 128'hDEAD);
        chkb("edge_res_tag", rtag_b, 1'b1);
        rr_b = 1'b1;
        step();
        rr_b = 1'b0;

        // Reset mid-job while in RUN
        dly_a = 0; key = 128'h44;
        jv_a = 1'b1;
        step();
        jv_a = 1'b0;
        repeat (8) step();
        chkb("midrun_core_rst", crst_a, 1'b0);
        chkb("midrun_busy", busy_a, 1'b1);
        rst = 1'b0;
        repeat (3) step();
        chkb("mid_rst_job_ready", jr_a, 1'b1);
        chkb("mid_rst_res_valid", rv_a, 1'b0);
        chkb("mid_rst_busy", busy_a, 1'b0);
        chkb("mid_rst_core_rst", crst_a, 1'b1);
        chkw("mid_rst_core_k", ck_a, '0);
        rst = 1'b1;
        step();

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
